// File: rtl/bcd_sub_serial_if.sv
// bcd_sub_serial_if
//   Handshake and operand/result bundle for the digit-serial BCD subtractor.
//   master : control side, drives start/a/b/bin and observes the results
//   slave  : subtractor side, drives busy/done/diff/bout/err
// Signals
//   start  request, sampled only while the subtractor is idle
//   a, b   packed BCD minuend / subtrahend, digit 0 in [3:0]
//   bin    borrow-in into digit 0
//   busy   high while digits are being processed
//   done   one-cycle pulse, diff/bout/err valid
//   diff   packed BCD result
//   bout   borrow-out of the top digit (1 = negative, diff is the 10^DIGITS complement)
//   err    some operand digit was > 9 in the accepted request
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, err
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial
//   Multi-digit BCD subtractor, one digit per clock, least significant digit
//   first, with the borrow carried between digits in a register. Computes
//   A - B - bin; the result is held until the next accepted start.
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  bcd_sub_serial_if slave modport (start/a/b/bin in, busy/done/diff/bout/err out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; previous result held
// RUN   | one digit processed per clock, DIGITS clocks total
// DONE  | done pulse for one cycle; start ignored
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_sub_serial_if.slave      bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_lat;
  logic [W-1:0]  b_lat;
  logic          borrow;
  logic [IW-1:0] idx;
  logic [W-1:0]  diff_q;
  logic          bout_q;
  logic          err_q;

  logic          accept;
  logic          last_digit;
  logic          in_err;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [5:0]    t;
  logic [5:0]    t_adj;
  logic [3:0]    d_dig;
  logic          t_neg;

  assign accept     = (state == IDLE) && bus.start;
  assign last_digit = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Any operand digit outside 0..9 flags the whole request.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9) in_err = 1'b1;
      if (bus.b[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // 6-bit two's complement holds the full range -16..15 of a_i - b_i - borrow.
  always_comb begin
    a_dig = a_lat[4*idx +: 4];
    b_dig = b_lat[4*idx +: 4];
    t     = {2'b00, a_dig} - {2'b00, b_dig} - {5'b00000, borrow};
    t_neg = t[5];
    t_adj = t + 6'd10;
    d_dig = t_neg ? t_adj[3:0] : t[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat  <= '0;
      b_lat  <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      a_lat  <= bus.a;
      b_lat  <= bus.b;
      borrow <= bus.bin;
      idx    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q  <= in_err;
    end else if (state == RUN) begin
      diff_q[4*idx +: 4] <= d_dig;
      borrow             <= t_neg;
      idx                <= idx + 1'b1;
      if (last_digit) begin
        // Invalid operands still take the full latency but report a zero result.
        if (err_q) begin
          diff_q <= '0;
          bout_q <= 1'b0;
        end else begin
          bout_q <= t_neg;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
module tb_bcd_sub_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_sub_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_diff, input logic exp_bout, input logic exp_err);
    int n;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'h7777;
    bus.b     = 16'h3333;
    bus.bin   = 1'b1;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      n++;
      @(negedge clk);
    end
    check("done_seen", {31'b0, bus.done}, 32'd1);
    check("busy_cycles", busy_cnt, DIGITS);
    check("diff", {16'b0, bus.diff}, {16'b0, exp_diff});
    check("bout", {31'b0, bus.bout}, {31'b0, exp_bout});
    check("err", {31'b0, bus.err}, {31'b0, exp_err});
    @(negedge clk);
    check("done_pulse_1cyc", {31'b0, bus.done}, 32'd0);
    check("diff_held", {16'b0, bus.diff}, {16'b0, exp_diff});
  endtask

  initial begin
    int n;
    int dones;
    int t_first;
    int t_second;

    vecs[0] = '{16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[2] = '{16'h1000, 16'h0999, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[4] = '{16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[5] = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{16'h0123, 16'h0123, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8] = '{16'h0999, 16'h1000, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[9] = '{16'h0009, 16'h000F, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_diff", {16'b0, bus.diff}, 32'd0);
    check("rst_bout_err", {30'b0, bus.bout, bus.err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_err);

    // Start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h5432; bus.b = 16'h1234; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h0001; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    n = 0;
    while (!bus.done && n < 20) begin n++; @(negedge clk); end
    check("ign_done_seen", {31'b0, bus.done}, 32'd1);
    dones = 1;
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h0002; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("ign_done_count", dones, 1);
    check("ign_diff", {16'b0, bus.diff}, 32'h4198);
    check("ign_bout", {31'b0, bus.bout}, 32'd0);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h00A0; bus.b = 16'h0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_diff", {16'b0, bus.diff}, 32'd0);
    check("midrst_bout", {31'b0, bus.bout}, 32'd0);
    check("midrst_err", {31'b0, bus.err}, 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", dones, 0);
    run_op(16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0);

    // Start held high: one operation every DIGITS+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1000; bus.b = 16'h0999; bus.bin = 1'b0;
    t_first = -1;
    t_second = -1;
    for (int k = 0; k < 30 && t_second < 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (t_first < 0) t_first = k;
        else t_second = k;
      end
    end
    bus.start = 1'b0;
    check("b2b_two_dones", {31'b0, (t_second >= 0)}, 32'd1);
    check("b2b_period", t_second - t_first, DIGITS + 2);
    check("b2b_diff", {16'b0, bus.diff}, 32'h0001);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
